// File: rtl/card_pkg.sv
// card_pkg: shared types and helpers for the memory-game match checker.
// Holds the checker state encoding, board geometry constants and the
// face-value extraction helper used by the checker and its interface.
package card_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_FIRST,
        ST_SECOND,
        ST_COMPARE,
        ST_SHOW,
        ST_OVER
    } state_t;

    localparam int NUM_PAIRS = 8;
    localparam int CARD_W    = 3;
    localparam int IDX_W     = 4;
    localparam int LAYOUT_W  = 2 * NUM_PAIRS * CARD_W;

    // Card i occupies layout[3i:3i+2]; the lowest layout index is the value MSB.
    function automatic logic [CARD_W-1:0] card_value(input logic [0:LAYOUT_W-1] layout,
                                                     input logic [IDX_W-1:0]    idx);
        return layout[int'(idx)*CARD_W +: CARD_W];
    endfunction

endpackage

// File: rtl/card_match_checker_if.sv
// card_match_checker_if: board load, flip handshake and game status bundle.
// master = assignment block / input-display controller side, slave = checker.
interface card_match_checker_if #(parameter int NUM_CARDS = 16);
    import card_pkg::*;

    logic                          load;
    logic [0:NUM_CARDS*CARD_W-1]   layout;
    logic                          flip_valid;
    logic [IDX_W-1:0]              flip_idx;
    logic                          flip_ready;
    logic [NUM_CARDS-1:0]          reveal_mask;
    logic [NUM_CARDS-1:0]          matched_mask;
    logic                          match_pulse;
    logic                          miss_pulse;
    logic                          reject_pulse;
    logic [3:0]                    pairs_left;
    logic                          game_over;
    logic [7:0]                    move_count;

    modport master (
        output load, layout, flip_valid, flip_idx,
        input  flip_ready, reveal_mask, matched_mask, match_pulse, miss_pulse,
               reject_pulse, pairs_left, game_over, move_count
    );

    modport slave (
        input  load, layout, flip_valid, flip_idx,
        output flip_ready, reveal_mask, matched_mask, match_pulse, miss_pulse,
               reject_pulse, pairs_left, game_over, move_count
    );

endinterface

// File: rtl/card_match_checker_hide_timer.sv
// hide_timer: loadable down-counter with a zero flag. Holds mismatched
// cards face-up; the count stops at zero until reloaded.
module hide_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    // Load wins over decrement; never wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/card_match_checker.sv
// card_match_checker: latches a shuffled 16-card board and referees player
// flips in pairs, revealing faces, recording matches and flagging game over.
// Optional build macro CARD_MOVE_COUNT_EN: when defined, move_count counts
// attempted pairs (saturating at 255); otherwise move_count is tied to 0.
module card_match_checker
    import card_pkg::*;
#(
    parameter int NUM_CARDS  = 16,
    parameter int HIDE_DELAY = 50
) (
    input  logic                 clk,
    input  logic                 resetn,
    card_match_checker_if.slave  bus
);

    localparam int TIMER_W = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;

    // One-hot mask bit for a card; card 0 sits at the mask MSB.
    function automatic logic [NUM_CARDS-1:0] card_bit(input logic [IDX_W-1:0] idx);
        logic [NUM_CARDS-1:0] b;
        b = '0;
        b[NUM_CARDS-1-int'(idx)] = 1'b1;
        return b;
    endfunction

    state_t                      state_q, state_d;
    logic [0:NUM_CARDS*CARD_W-1] layout_q, layout_d;
    logic [NUM_CARDS-1:0]        matched_q, matched_d;
    logic [NUM_CARDS-1:0]        reveal_q, reveal_d;
    logic [IDX_W-1:0]            idx_a_q, idx_a_d;
    logic [IDX_W-1:0]            idx_b_q, idx_b_d;
    logic [3:0]                  pairs_left_q, pairs_left_d;
    logic                        flip_ready_q, flip_ready_d;
    logic                        game_over_q, game_over_d;
    logic                        match_q, match_d;
    logic                        miss_q, miss_d;
    logic                        reject_q, reject_d;
    logic                        flip_acc;
    logic [NUM_CARDS-1:0]        flip_bit, bit_a, bit_b;
    logic                        timer_load, timer_dec, timer_zero;

    assign flip_acc = bus.flip_valid && flip_ready_q;
    assign flip_bit = card_bit(bus.flip_idx);
    assign bit_a    = card_bit(idx_a_q);
    assign bit_b    = card_bit(idx_b_q);

    hide_timer #(.WIDTH(TIMER_W)) u_hide_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (timer_load),
        .load_val (TIMER_W'(HIDE_DELAY - 1)),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Game sequencing: a load restarts from any state, otherwise step the pair protocol.
    always_comb begin
        state_d      = state_q;
        layout_d     = layout_q;
        matched_d    = matched_q;
        reveal_d     = reveal_q;
        idx_a_d      = idx_a_q;
        idx_b_d      = idx_b_q;
        pairs_left_d = pairs_left_q;
        match_d      = 1'b0;
        miss_d       = 1'b0;
        reject_d     = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;
        if (bus.load) begin
            state_d      = ST_FIRST;
            layout_d     = bus.layout;
            matched_d    = '0;
            reveal_d     = '0;
            pairs_left_d = 4'(NUM_PAIRS);
        end else begin
            case (state_q)
                ST_EMPTY: ;
                ST_FIRST: begin
                    if (flip_acc) begin
                        if ((matched_q & flip_bit) != '0) begin
                            reject_d = 1'b1;
                        end else begin
                            reveal_d = reveal_q | flip_bit;
                            idx_a_d  = bus.flip_idx;
                            state_d  = ST_SECOND;
                        end
                    end
                end
                ST_SECOND: begin
                    if (flip_acc) begin
                        if (bus.flip_idx == idx_a_q || (matched_q & flip_bit) != '0) begin
                            reject_d = 1'b1;
                        end else begin
                            reveal_d = reveal_q | flip_bit;
                            idx_b_d  = bus.flip_idx;
                            state_d  = ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (card_value(layout_q, idx_a_q) == card_value(layout_q, idx_b_q)) begin
                        matched_d    = matched_q | bit_a | bit_b;
                        match_d      = 1'b1;
                        pairs_left_d = pairs_left_q - 4'd1;
                        state_d      = (pairs_left_q == 4'd1) ? ST_OVER : ST_FIRST;
                    end else begin
                        miss_d     = 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (timer_zero) begin
                        reveal_d = reveal_q & ~(bit_a | bit_b);
                        state_d  = ST_FIRST;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                ST_OVER: begin
                    matched_d = '1;
                    reveal_d  = '1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        flip_ready_d = (state_d == ST_FIRST) || (state_d == ST_SECOND);
        game_over_d  = (state_d == ST_OVER);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_EMPTY;
            layout_q     <= '0;
            matched_q    <= '0;
            reveal_q     <= '0;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            pairs_left_q <= '0;
            flip_ready_q <= 1'b0;
            game_over_q  <= 1'b0;
            match_q      <= 1'b0;
            miss_q       <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            layout_q     <= layout_d;
            matched_q    <= matched_d;
            reveal_q     <= reveal_d;
            idx_a_q      <= idx_a_d;
            idx_b_q      <= idx_b_d;
            pairs_left_q <= pairs_left_d;
            flip_ready_q <= flip_ready_d;
            game_over_q  <= game_over_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            reject_q     <= reject_d;
        end
    end

`ifdef CARD_MOVE_COUNT_EN
    logic [7:0] moves_q, moves_d;

    // Count each compared pair, saturating; a new board restarts the count.
    always_comb begin
        moves_d = moves_q;
        if (bus.load) begin
            moves_d = '0;
        end else if (state_q == ST_COMPARE && moves_q != 8'hFF) begin
            moves_d = moves_q + 8'd1;
        end
    end

    // Move counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            moves_q <= '0;
        end else begin
            moves_q <= moves_d;
        end
    end

    assign bus.move_count = moves_q;
`else
    assign bus.move_count = '0;
`endif

    assign bus.flip_ready   = flip_ready_q;
    assign bus.reveal_mask  = reveal_q;
    assign bus.matched_mask = matched_q;
    assign bus.match_pulse  = match_q;
    assign bus.miss_pulse   = miss_q;
    assign bus.reject_pulse = reject_q;
    assign bus.pairs_left   = pairs_left_q;
    assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_card_match_checker.sv
// tb_card_match_checker: scoreboard bench for card_match_checker. Flip
// outcomes are predicted by a small game model when driven and compared
// when the DUT pulses.
module tb_card_match_checker;
    import card_pkg::*;

`ifdef CARD_MOVE_COUNT_EN
    localparam int MOVE_EN = 1;
`else
    localparam int MOVE_EN = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    card_match_checker_if #(.NUM_CARDS(16)) bus ();

    card_match_checker #(.NUM_CARDS(16), .HIDE_DELAY(50)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int          kind;     // 1 match, 2 miss, 3 reject
        int          due;
        logic [15:0] matched;
        logic [15:0] reveal;
        logic [3:0]  pairs;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [2:0]  faces [16];
    logic [15:0] m_matched, m_reveal, m_show_bits;
    int          m_pairs;
    bit          m_second;
    logic [3:0]  m_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: pops the scoreboard whenever the DUT reports a flip outcome.
    int   mon_k;
    exp_t mon_e;
    always @(negedge clk) begin
        if (resetn) begin
            mon_k = bus.match_pulse ? 1 : bus.miss_pulse ? 2 : bus.reject_pulse ? 3 : 0;
            if (mon_k != 0) begin
                check("pulse_onehot", int'(bus.match_pulse) + int'(bus.miss_pulse) + int'(bus.reject_pulse), 1);
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", mon_k, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("pulse_kind", mon_k, mon_e.kind);
                    check("pulse_cycle", cyc, mon_e.due);
                    check("matched_mask", bus.matched_mask, mon_e.matched);
                    check("reveal_mask", bus.reveal_mask, mon_e.reveal);
                    check("pairs_left", bus.pairs_left, mon_e.pairs);
                end
            end
        end
    end

    function automatic logic [0:47] build_layout();
        logic [0:47] lay;
        for (int i = 0; i < 16; i++) lay[i*3 +: 3] = faces[i];
        return lay;
    endfunction

    task automatic model_restart();
        m_matched = '0;
        m_reveal  = '0;
        m_pairs   = 8;
        m_second  = 1'b0;
    endtask

    task automatic load_layout();
        bus.layout = build_layout();
        bus.load   = 1'b1;
        @(posedge clk); #1;
        bus.load   = 1'b0;
        model_restart();
        $display("txn load cycle=%0d", cyc);
    endtask

    // Accepted flip; returns 1 ns after the accepting edge.
    task automatic flip(input logic [3:0] idx);
        exp_t        e;
        logic [15:0] b, ba;
        b = 16'h8000 >> idx;
        bus.flip_valid = 1'b1;
        bus.flip_idx   = idx;
        @(posedge clk); #1;
        bus.flip_valid = 1'b0;
        e.kind = 0;
        e.due  = cyc;
        if (!m_second) begin
            if ((m_matched & b) != 0) e.kind = 3;
            else begin
                m_reveal |= b;
                m_a       = idx;
                m_second  = 1'b1;
            end
        end else begin
            ba = 16'h8000 >> m_a;
            if (idx == m_a || (m_matched & b) != 0) e.kind = 3;
            else begin
                m_reveal |= b;
                m_second  = 1'b0;
                e.due     = cyc + 1;
                if (faces[m_a] == faces[idx]) begin
                    e.kind     = 1;
                    m_matched |= b | ba;
                    m_pairs--;
                end else begin
                    e.kind      = 2;
                    m_show_bits = b | ba;
                end
            end
        end
        e.matched = m_matched;
        e.reveal  = m_reveal;
        e.pairs   = 4'(m_pairs);
        if (e.kind == 2) m_reveal = m_matched;
        if (e.kind != 0) sb_q.push_back(e);
        else check("reveal_latency", bus.reveal_mask, m_reveal);
        $display("txn flip idx=%0d outcome=%0d cycle=%0d", idx, e.kind, cyc);
    endtask

    // Flip request the DUT is expected to ignore (not ready).
    task automatic poke(input logic [3:0] idx);
        bus.flip_valid = 1'b1;
        bus.flip_idx   = idx;
        @(posedge clk); #1;
        bus.flip_valid = 1'b0;
        $display("txn poke idx=%0d cycle=%0d", idx, cyc);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
    endtask

    // Called right after a mismatching second flip is accepted.
    task automatic measure_show();
        int vis, fr_bad;
        @(negedge clk);
        check("ready_in_compare", bus.flip_ready, 0);
        vis = 0;
        fr_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((bus.reveal_mask & m_show_bits) != m_show_bits) break;
            vis++;
            if (bus.flip_ready) fr_bad++;
        end
        check("show_cycles", vis, 50);
        check("ready_low_in_show", fr_bad, 0);
        check("reveal_after_show", bus.reveal_mask, m_reveal);
        check("ready_after_show", bus.flip_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.flip_ready, 0);
        check({tag, "_reveal"}, bus.reveal_mask, 0);
        check({tag, "_matched"}, bus.matched_mask, 0);
        check({tag, "_pairs"}, bus.pairs_left, 0);
        check({tag, "_over"}, bus.game_over, 0);
        check({tag, "_moves"}, bus.move_count, 0);
        check({tag, "_pulses"}, {bus.match_pulse, bus.miss_pulse, bus.reject_pulse}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:47] lay_b;
        bus.load = 1'b0;
        bus.layout = '0;
        bus.flip_valid = 1'b0;
        bus.flip_idx = '0;
        model_restart();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // EMPTY ignores flips
        poke(4'd0);
        check("empty_ready", bus.flip_ready, 0);
        check("empty_reveal", bus.reveal_mask, 0);
        repeat (2) @(posedge clk);
        #1;

        // Layout A: {0,0,1,1,...,7,7}
        for (int i = 0; i < 16; i++) faces[i] = 3'(i / 2);
        load_layout();
        check("load_pairs", bus.pairs_left, 8);
        check("load_ready", bus.flip_ready, 1);
        check("load_reveal", bus.reveal_mask, 0);
        check("load_moves", bus.move_count, 0);

        flip(4'd0);
        flip(4'd1);
        drain();
        check("match_matched", bus.matched_mask, 16'hC000);
        check("match_pairs", bus.pairs_left, 7);
        check("match_moves", bus.move_count, 1 * MOVE_EN);

        flip(4'd2);
        flip(4'd4);
        measure_show();
        drain();
        check("miss_moves", bus.move_count, 2 * MOVE_EN);

        flip(4'd0);             // matched card in FIRST
        drain();
        flip(4'd3);
        flip(4'd3);             // same index in SECOND
        flip(4'd2);
        drain();
        check("second_match_matched", bus.matched_mask, 16'hF000);
        check("second_match_pairs", bus.pairs_left, 6);

        // Load in SECOND alongside a flip: load wins
        flip(4'd5);
        for (int i = 0; i < 16; i++) faces[i] = 3'(i % 8);
        lay_b = build_layout();
        bus.layout = lay_b;
        bus.load = 1'b1;
        bus.flip_valid = 1'b1;
        bus.flip_idx = 4'd6;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.flip_valid = 1'b0;
        model_restart();
        $display("txn load+flip cycle=%0d", cyc);
        check("reload_reveal", bus.reveal_mask, 0);
        check("reload_matched", bus.matched_mask, 0);
        check("reload_pairs", bus.pairs_left, 8);
        check("reload_ready", bus.flip_ready, 1);
        check("reload_moves", bus.move_count, 0);
        repeat (3) @(posedge clk);
        #1;

        for (int p = 0; p < 8; p++) begin
            flip(4'(p));
            flip(4'(p + 8));
            drain();
        end
        check("over_flag", bus.game_over, 1);
        check("over_pairs", bus.pairs_left, 0);
        check("over_ready", bus.flip_ready, 0);
        check("over_matched", bus.matched_mask, 16'hFFFF);
        check("over_reveal", bus.reveal_mask, 16'hFFFF);
        check("over_moves", bus.move_count, 8 * MOVE_EN);
        poke(4'd3);
        repeat (2) @(posedge clk);
        #1;
        check("over_hold", bus.game_over, 1);
        check("over_hold_reveal", bus.reveal_mask, 16'hFFFF);

        // Reset during SHOW
        for (int i = 0; i < 16; i++) faces[i] = 3'(i / 2);
        load_layout();
        flip(4'd0);
        flip(4'd2);
        repeat (10) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("show_reset");
        check("sb_at_reset", sb_q.size(), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        poke(4'd6);
        check("post_reset_reveal", bus.reveal_mask, 0);
        check("post_reset_ready", bus.flip_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_pairs", bus.pairs_left, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
